dpu_sched: RTL

Round-robin scheduler that shares one 2x2 matrix-multiply datapath (dpu) among NUM_REQ requesters. It accepts one operand pair per valid/ready handshake and drives the operands to the datapath. It waits the datapath's fixed latency, captures the four 33-bit products, and returns them tagged with the requester index on a single response channel. It sits between the request-side interconnect and the dpu instance; only one operation is in flight at a time.

---
 rtl/dpu_sched_pkg.sv | 33 +++
 rtl/dpu_sched_rr_arbiter.sv | 38 +++
 rtl/dpu_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/dpu_sched_pkg.sv
// Shared types, widths and the round-robin pick function for the dpu scheduler.
package dpu_sched_pkg;

   localparam int MAT_W   = 64;           // {m11,m12,m21,m22}, 16 b each
   localparam int ELEM_W  = 33;           // one product element
   localparam int RES_W   = 4 * ELEM_W;   // {o11,o12,o21,o22} = 132 b
   localparam int MAX_REQ = 8;            // widest requester vector supported

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   // One-hot grant: search starts at ptr+1 and wraps modulo n.
   // valid is zero-extended to MAX_REQ so the function serves every NUM_REQ.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] grant;
      logic [2:0]         idx;
      grant = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         if (k <= n) begin
            idx = 3'((int'(ptr) + k) % n);
            if (valid[idx] && (grant == '0)) grant[idx] = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/dpu_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advanced on accept.
module rr_arbiter
   import dpu_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_accept,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx
);

   logic [IDX_W-1:0]   r_ptr;
   logic [MAX_REQ-1:0] w_pick;

   assign w_pick  = rr_pick(MAX_REQ'(i_req), 3'(r_ptr), NUM_REQ);
   assign o_grant = w_pick[NUM_REQ-1:0];

   // Encode the one-hot grant into an index for the pointer and the id register.
   always_comb begin
      // NOTE: default assigned before the loop so no path leaves o_grant_idx unassigned (no latch).
      o_grant_idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (w_pick[i]) o_grant_idx = IDX_W'(i);
      end
   end

   // Pointer remembers the last winner; reset value makes requester 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n)        r_ptr <= IDX_W'(NUM_REQ - 1);
      else if (i_accept) r_ptr <= o_grant_idx;
   end

endmodule

// File: rtl/dpu_sched.sv
// Round-robin scheduler sharing one 2x2 matrix-multiply datapath among NUM_REQ
// requesters; one operation in flight, results returned tagged with requester id.
module dpu_sched
   import dpu_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DPU_LAT = 1,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*MAT_W-1:0] req_mat1,
   input  logic [NUM_REQ*MAT_W-1:0] req_mat2,
   output logic [MAT_W-1:0]         dpu_mat1,
   output logic [MAT_W-1:0]         dpu_mat2,
   output logic                     dpu_busy,
   input  logic [RES_W-1:0]         dpu_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDX_W-1:0]         rsp_id,
   output logic [RES_W-1:0]         rsp_out,
   output logic [31:0]              done_cnt
);

   state_t             r_state;
   state_t             w_next;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_accept;
   logic [IDX_W-1:0]   r_id;
   logic [2:0]         r_cnt;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req_valid),
      .i_accept    (w_accept),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   // Next state plus the combinational ready/accept, valid only while IDLE.
   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      w_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               req_ready = w_grant;
               w_accept  = 1'b1;
               w_next    = RUN;
            end
         end
         RUN:     if (r_cnt == 3'd1) w_next = CAPT;
         CAPT:    w_next = RESP;
         RESP:    if (rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Operand load, latency count, result capture and response handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dpu_mat1  <= '0;
         dpu_mat2  <= '0;
         dpu_busy  <= 1'b0;
         r_id      <= '0;
         r_cnt     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_out   <= '0;
         done_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  dpu_mat1 <= req_mat1[w_grant_idx*MAT_W +: MAT_W];
                  dpu_mat2 <= req_mat2[w_grant_idx*MAT_W +: MAT_W];
                  r_id     <= w_grant_idx;
                  dpu_busy <= 1'b1;
                  r_cnt    <= 3'(DPU_LAT);
               end
            end
            RUN: begin
               r_cnt <= r_cnt - 3'd1;
            end
            CAPT: begin
               rsp_out   <= dpu_out;
               rsp_id    <= r_id;
               rsp_valid <= 1'b1;
               dpu_busy  <= 1'b0;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  done_cnt  <= done_cnt + 32'd1;   // wraps to 0 after 0xFFFF_FFFF
               end
            end
            default: ;
         endcase
      end
   end

endmodule
